nr_inverse_sched: RTL and testbench

Round-robin scheduler that shares one fully pipelined `nr_inverse` reciprocal unit among `N_REQ` requesters in the arithmetic encoder.
- Issues at most one divisor per cycle.
- Tracks each in-flight operation with a tag pipeline matched to the unit latency.
- Steers each result into a per-requester response FIFO.
- Uses credits so a result is never dropped under response backpressure.

---
 rtl/nr_inverse_sched.sv | 239 +++++++++++++++++++++++
 tb/tb_nr_inverse_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nr_inverse_sched.sv
// nr_inverse_sched
// Shares one fully pipelined nr_inverse reciprocal unit among N_REQ
// requesters. A round-robin arbiter issues at most one divisor per cycle.
// A tag pipe that matches the unit latency follows each operation, and every
// result is steered into a per-requester first-word-fall-through response
// FIFO. Per-requester credits cover FIFO occupancy plus in-flight work, so a
// returning result always finds room, even when the requester stalls its
// response side.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   req_valid/ready  per-requester issue handshake (ready is the grant)
//   req_divisor      per-requester 16-bit divisor, requester i at [16*i +: 16]
//   div_divisor      registered divisor to nr_inverse divisor_in
//   div_valid        registered valid to nr_inverse valid_in
//   div_inverse      nr_inverse inverse_out
//   div_shift        nr_inverse shift_out
//   div_valid_out    nr_inverse valid_out
//   rsp_valid/ready  per-requester response handshake (valid = FIFO not empty)
//   rsp_inverse      FIFO head inverse, requester i at [18*i +: 18]
//   rsp_shift        FIFO head shift, requester i at [4*i +: 4]
//   rsp_dz           FIFO head came from a zero divisor
//   err_tag          sticky: tag/valid mismatch or FIFO overflow attempt
module nr_inverse_sched #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 25,
  parameter int DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*16-1:0]  req_divisor,
  output logic [15:0]          div_divisor,
  output logic                 div_valid,
  input  logic [17:0]          div_inverse,
  input  logic [3:0]           div_shift,
  input  logic                 div_valid_out,
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [N_REQ*18-1:0]  rsp_inverse,
  output logic [N_REQ*4-1:0]   rsp_shift,
  output logic [N_REQ-1:0]     rsp_dz,
  output logic                 err_tag
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int WW  = $clog2(LATENCY + 2);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);
  localparam logic [WW-1:0] WARM_DONE  = WW'(LATENCY + 1);

  // Arbitration state and credits
  logic [IDW-1:0] last;
  logic [CW-1:0]  credit [N_REQ];

  // Grant decode
  logic           grant_any;
  logic [IDW-1:0] grant_id;
  logic [15:0]    sel_div;
  int             idx;

  // Tag travelling with div_valid, then LATENCY stages behind it
  logic           iss_v;
  logic [IDW-1:0] iss_id;
  logic           iss_dz;
  logic           pipe_v  [LATENCY];
  logic [IDW-1:0] pipe_id [LATENCY];
  logic           pipe_dz [LATENCY];
  logic           out_v;
  logic [IDW-1:0] out_id;
  logic           out_dz;

  // Response FIFOs
  logic [22:0]    mem    [N_REQ][DEPTH];
  logic [AW-1:0]  rd_ptr [N_REQ];
  logic [AW-1:0]  wr_ptr [N_REQ];
  logic [CW-1:0]  count  [N_REQ];
  logic [N_REQ-1:0] pop;
  logic [N_REQ-1:0] wr_req;
  logic [N_REQ-1:0] wr_ok;
  logic [N_REQ-1:0] overflow;
  logic [22:0]    wdata;

  // Warm-up counter
  logic [WW-1:0]  warm_cnt;
  logic           warm_done;

  // Round-robin search starting just after the last grantee. Eligibility needs
  // a pending request and a spare credit; the response-side ready is never
  // consulted here, so a stalled consumer only loses its own credits. The
  // grant is held off entirely while reset is asserted.
  always_comb begin
    req_ready = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    sel_div   = '0;
    idx       = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = int'(last) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_any && rst_n && req_valid[idx] && (credit[idx] != '0)) begin
        grant_any      = 1'b1;
        grant_id       = IDW'(idx);
        sel_div        = req_divisor[idx*16 +: 16];
        req_ready[idx] = 1'b1;
      end
    end
  end

  // The tag at the end of the pipe is the one expected to line up with the
  // unit's valid_out in this cycle.
  assign out_v     = pipe_v[LATENCY-1];
  assign out_id    = pipe_id[LATENCY-1];
  assign out_dz    = pipe_dz[LATENCY-1];
  assign warm_done = (warm_cnt == WARM_DONE);

  // A zero divisor gets a saturated reciprocal regardless of what the unit
  // produced, so the requester never has to interpret the unit's output for
  // that case.
  assign wdata = out_dz ? {18'h3FFFF, 4'h0, 1'b1}
                        : {div_inverse, div_shift, 1'b0};

  // Head-of-FIFO presentation. Outputs are forced to zero while a FIFO is
  // empty so stale memory never shows on the response bus.
  always_comb begin
    rsp_valid   = '0;
    rsp_inverse = '0;
    rsp_shift   = '0;
    rsp_dz      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid[i] = (count[i] != '0);
      if (rsp_valid[i]) begin
        {rsp_inverse[i*18 +: 18], rsp_shift[i*4 +: 4], rsp_dz[i]} = mem[i][rd_ptr[i]];
      end
    end
  end

  // Write steering. A write is accepted if the FIFO has room or is being
  // popped in the same cycle; anything else is an overflow, which credits
  // should make impossible.
  always_comb begin
    pop      = rsp_valid & rsp_ready;
    wr_req   = '0;
    wr_ok    = '0;
    overflow = '0;
    for (int i = 0; i < N_REQ; i++) begin
      wr_req[i]   = out_v && div_valid_out && (int'(out_id) == i);
      wr_ok[i]    = wr_req[i] && ((count[i] != CREDIT_MAX) || pop[i]);
      overflow[i] = wr_req[i] && !wr_ok[i];
    end
  end

  // Issue register, round-robin pointer and credits. div_divisor holds its
  // last value on idle cycles. Credits go down on grant and up on pop; both
  // together for the same requester cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last        <= IDW'(N_REQ - 1);
      div_valid   <= 1'b0;
      div_divisor <= '0;
      iss_v       <= 1'b0;
      iss_id      <= '0;
      iss_dz      <= 1'b0;
      for (int i = 0; i < N_REQ; i++) credit[i] <= CREDIT_MAX;
    end else begin
      div_valid <= grant_any;
      iss_v     <= grant_any;
      iss_id    <= grant_id;
      iss_dz    <= grant_any && (sel_div == 16'h0);
      if (grant_any) begin
        div_divisor <= sel_div;
        last        <= grant_id;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ready[i] && !pop[i]) credit[i] <= credit[i] - 1'b1;
        else if (pop[i] && !req_ready[i]) credit[i] <= credit[i] + 1'b1;
      end
    end
  end

  // Tag pipe: shifts every cycle, invalid tags fill idle slots. Reset drops
  // everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < LATENCY; j++) begin
        pipe_v[j]  <= 1'b0;
        pipe_id[j] <= '0;
        pipe_dz[j] <= 1'b0;
      end
    end else begin
      pipe_v[0]  <= iss_v;
      pipe_id[0] <= iss_id;
      pipe_dz[0] <= iss_dz;
      for (int j = 1; j < LATENCY; j++) begin
        pipe_v[j]  <= pipe_v[j-1];
        pipe_id[j] <= pipe_id[j-1];
        pipe_dz[j] <= pipe_dz[j-1];
      end
    end
  end

  // FIFO pointers and occupancy, plus the warm-up counter and the sticky
  // error. The unit has no reset, so valid_out pulses left over from before
  // reset are only trusted once the counter has covered the full latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      warm_cnt <= '0;
      err_tag  <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (pop[i])   rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (wr_ok[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        case ({wr_ok[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
      if (!warm_done) warm_cnt <= warm_cnt + 1'b1;
      if ((warm_done && (out_v != div_valid_out)) || (|overflow)) err_tag <= 1'b1;
    end
  end

  // FIFO storage needs no reset; its contents are only visible through the
  // occupancy-gated head logic.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (wr_ok[i]) mem[i][wr_ptr[i]] <= wdata;
    end
  end

endmodule

// File: tb/tb_nr_inverse_sched.sv
// Testbench for nr_inverse_sched. Contains a behavioural stand-in for the
// nr_inverse unit (fixed latency, simple invertible data mapping, no reset)
// and a per-requester response scoreboard.
module tb_nr_inverse_sched;

  localparam int N   = 4;
  localparam int LAT = 25;
  localparam int D   = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*16-1:0] req_divisor;
  logic [15:0]     div_divisor;
  logic            div_valid;
  logic [17:0]     div_inverse;
  logic [3:0]      div_shift;
  logic            div_valid_out;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [N*18-1:0] rsp_inverse;
  logic [N*4-1:0]  rsp_shift;
  logic [N-1:0]    rsp_dz;
  logic            err_tag;
  logic            inject;

  int checks = 0;
  int passed = 0;

  nr_inverse_sched #(.N_REQ(N), .LATENCY(LAT), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_divisor(req_divisor),
    .div_divisor(div_divisor), .div_valid(div_valid),
    .div_inverse(div_inverse), .div_shift(div_shift), .div_valid_out(div_valid_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_inverse(rsp_inverse), .rsp_shift(rsp_shift), .rsp_dz(rsp_dz),
    .err_tag(err_tag)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data mapping of the stand-in unit
  function automatic logic [17:0] unitInv(input logic [15:0] d);
    return {2'b01, d} ^ 18'h00155;
  endfunction

  function automatic logic [3:0] unitShift(input logic [15:0] d);
    return d[3:0] ^ 4'h5;
  endfunction

  // Response a requester should see for a divisor it issued
  function automatic logic [22:0] expRsp(input logic [15:0] d);
    if (d == 16'h0) return {18'h3FFFF, 4'h0, 1'b1};
    return {unitInv(d), unitShift(d), 1'b0};
  endfunction

  // Stand-in nr_inverse: samples valid_in each edge, presents it LAT cycles
  // later; inject lets the bench force a spurious valid_out pulse
  logic        uv [LAT];
  logic [15:0] ud [LAT];
  always @(posedge clk) begin
    uv[0] <= div_valid;
    ud[0] <= div_divisor;
    for (int j = 1; j < LAT; j++) begin
      uv[j] <= uv[j-1];
      ud[j] <= ud[j-1];
    end
  end
  assign div_valid_out = uv[LAT-1] | inject;
  assign div_inverse   = unitInv(ud[LAT-1]);
  assign div_shift     = unitShift(ud[LAT-1]);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Scoreboard: records each accepted divisor and checks every popped
  // response against the oldest outstanding one for that requester
  logic [22:0] exp_mem [N][64];
  int exp_wr [N];
  int exp_rd [N];
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        exp_wr[i] = 0;
        exp_rd[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_mem[i][exp_wr[i] % 64] = expRsp(req_divisor[i*16 +: 16]);
          exp_wr[i]++;
        end
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (exp_rd[i] == exp_wr[i]) begin
            checkOutput($sformatf("rsp_unexpected_%0d", i), 32'(rsp_valid[i]), 32'd0);
          end else begin
            checkOutput($sformatf("rsp_order_%0d", i),
                        {9'b0, rsp_inverse[i*18 +: 18], rsp_shift[i*4 +: 4], rsp_dz[i]},
                        {9'b0, exp_mem[i][exp_rd[i] % 64]});
            exp_rd[i]++;
          end
        end
      end
    end
  end

  typedef struct {
    logic [3:0] rv;
    logic [3:0] exp_ready;
  } vec_t;
  vec_t vecs [12];

  task automatic applyStimulus(input vec_t v, input int n);
    req_valid = v.rv;
    for (int i = 0; i < N; i++) req_divisor[i*16 +: 16] = 16'((i + 1) * 4096 + n);
    #1;
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    req_valid = '0;
    inject    = 1'b0;
    rsp_ready = '1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drainAndCheck(input string tag);
    req_valid = '0;
    rsp_ready = '1;
    repeat (40) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      checkOutput($sformatf("%s_drain_%0d", tag, i), 32'(exp_rd[i]), 32'(exp_wr[i]));
    checkOutput($sformatf("%s_err_tag", tag), 32'(err_tag), 32'd0);
  endtask

  initial begin
    logic [15:0] prev_div;
    int n;
    int cnt0;
    int cnt2;
    bit saw_rsp;

    rst_n       = 1'b0;
    req_valid   = '0;
    req_divisor = '0;
    rsp_ready   = '1;
    inject      = 1'b0;

    // Grant sequence from reset (last = 3) with hand-worked round-robin order
    vecs[0]  = '{4'b0001, 4'b0001};
    vecs[1]  = '{4'b1111, 4'b0010};
    vecs[2]  = '{4'b1111, 4'b0100};
    vecs[3]  = '{4'b1001, 4'b1000};
    vecs[4]  = '{4'b1001, 4'b0001};
    vecs[5]  = '{4'b1010, 4'b0010};
    vecs[6]  = '{4'b0010, 4'b0010};
    vecs[7]  = '{4'b0000, 4'b0000};
    vecs[8]  = '{4'b0101, 4'b0100};
    vecs[9]  = '{4'b0011, 4'b0001};
    vecs[10] = '{4'b1100, 4'b0100};
    vecs[11] = '{4'b1000, 4'b1000};

    // Reset state, with requests pending to show the grant is held off
    req_valid = 4'hF;
    #2;
    $display("[TB] reset state");
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_div_valid", 32'(div_valid), 32'd0);
    checkOutput("rst_div_divisor", 32'(div_divisor), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_inverse", 32'(rsp_inverse[17:0]), 32'd0);
    checkOutput("rst_err_tag", 32'(err_tag), 32'd0);
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Table of grant patterns
    $display("[TB] round-robin table");
    prev_div = 16'h0;
    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v], v);
      checkOutput($sformatf("tbl_ready_%0d", v), 32'(req_ready), 32'(vecs[v].exp_ready));
      for (int i = 0; i < N; i++)
        if (vecs[v].exp_ready[i]) prev_div = 16'((i + 1) * 4096 + v);
      @(posedge clk);
      #1;
      checkOutput($sformatf("tbl_div_valid_%0d", v), 32'(div_valid), 32'(vecs[v].exp_ready != 4'b0));
      checkOutput($sformatf("tbl_div_divisor_%0d", v), 32'(div_divisor), 32'(prev_div));
    end
    drainAndCheck("tbl");

    // Single request latency: rsp_valid in cycle k+2+LAT, i.e. LAT+1 edges
    // after the accepting edge k
    $display("[TB] single request latency");
    doReset();
    req_divisor[15:0] = 16'h8000;
    req_valid = 4'b0001;
    #1;
    checkOutput("lat_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_valid = '0;
    checkOutput("lat_div_valid", 32'(div_valid), 32'd1);
    checkOutput("lat_div_divisor", 32'(div_divisor), 32'h8000);
    @(posedge clk);
    #1;
    n = 1;
    checkOutput("lat_div_valid_idle", 32'(div_valid), 32'd0);
    checkOutput("lat_div_divisor_hold", 32'(div_divisor), 32'h8000);
    while (!rsp_valid[0] && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("lat_edges", 32'(n), 32'(LAT + 1));
    checkOutput("lat_inverse", 32'(rsp_inverse[17:0]), 32'(unitInv(16'h8000)));
    checkOutput("lat_shift", 32'(rsp_shift[3:0]), 32'(unitShift(16'h8000)));
    checkOutput("lat_dz", 32'(rsp_dz[0]), 32'd0);
    drainAndCheck("lat");

    // All four requesting: strict rotation until credits (D each) run out
    $display("[TB] continuous rotation");
    doReset();
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < N; i++) req_divisor[i*16 +: 16] = {4'(i), 12'(c)};
      req_valid = 4'hF;
      #1;
      checkOutput($sformatf("rot_%0d", c), 32'(req_ready), 32'(4'b0001 << (c % 4)));
      @(posedge clk);
      #1;
    end
    #1;
    checkOutput("rot_credits_out", 32'(req_ready), 32'd0);
    for (int c = 16; c < 80; c++) begin
      for (int i = 0; i < N; i++) req_divisor[i*16 +: 16] = {4'(i), 12'(c)};
      @(posedge clk);
      #1;
    end
    drainAndCheck("rot");

    // Requester 2 stalls its responses: exactly D grants, others keep going
    $display("[TB] credit backpressure");
    doReset();
    cnt0 = 0;
    cnt2 = 0;
    rsp_ready = 4'b1011;
    req_divisor[15:0]  = 16'h0123;
    req_divisor[47:32] = 16'h0456;
    req_valid = 4'b0101;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (req_ready[0]) cnt0++;
      if (req_ready[2]) cnt2++;
      @(posedge clk);
      #1;
      req_divisor[15:0]  = 16'(16'h0123 + c);
      req_divisor[47:32] = 16'(16'h0456 + c);
    end
    checkOutput("bp_grants2", 32'(cnt2), 32'(D));
    checkOutput("bp_others_move", 32'(cnt0 >= 8), 32'd1);
    req_valid = 4'b0100;
    rsp_ready = 4'b1111;
    #1;
    checkOutput("bp_stalled", 32'(req_ready[2]), 32'd0);
    checkOutput("bp_full_valid", 32'(rsp_valid[2]), 32'd1);
    @(posedge clk);
    #1;
    rsp_ready = 4'b1011;
    #1;
    checkOutput("bp_one_credit", 32'(req_ready[2]), 32'd1);
    @(posedge clk);
    #2;
    checkOutput("bp_credit_used", 32'(req_ready[2]), 32'd0);
    drainAndCheck("bp");

    // Zero divisor between two normal ones
    $display("[TB] divide by zero");
    doReset();
    req_divisor[15:0]  = 16'h1234;
    req_divisor[31:16] = 16'h0000;
    req_divisor[47:32] = 16'h00FF;
    req_valid = 4'b0111;
    repeat (3) @(posedge clk);
    #1;
    req_valid = '0;
    n = 0;
    while (!rsp_valid[1] && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("dz_seen", 32'(rsp_valid[1]), 32'd1);
    checkOutput("dz_inverse", 32'(rsp_inverse[35:18]), 32'h3FFFF);
    checkOutput("dz_shift", 32'(rsp_shift[7:4]), 32'd0);
    checkOutput("dz_flag", 32'(rsp_dz[1]), 32'd1);
    drainAndCheck("dz");

    // Reset with 10 ops in flight, then a spurious pulse during warm-up
    $display("[TB] reset mid-stream");
    doReset();
    req_valid = 4'hF;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    saw_rsp = 1'b0;
    for (int c = 0; c < 40; c++) begin
      inject = (c == 5);
      #1;
      if (rsp_valid != '0) saw_rsp = 1'b1;
      @(posedge clk);
      #1;
    end
    inject = 1'b0;
    #1;
    checkOutput("mid_no_rsp", 32'(saw_rsp), 32'd0);
    checkOutput("mid_no_rsp_now", 32'(rsp_valid), 32'd0);
    checkOutput("mid_err_clear", 32'(err_tag), 32'd0);
    inject = 1'b1;
    @(posedge clk);
    #1;
    inject = 1'b0;
    checkOutput("mid_err_set", 32'(err_tag), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("mid_err_sticky", 32'(err_tag), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
